// File: rtl/srcnn_pkg.sv
// Shared definitions for the SRCNN convolution MAC/accumulate datapath.
// Contents:
//   state_t      - accumulator FSM states (S_ACC, S_BIAS, S_OUT)
//   clog2_int    - constant ceiling log2
//   acc_width    - signed accumulator width for a window of TAPS products
//   sum_width    - signed width holding accumulator plus sign-extended bias
//   work_width   - internal width for rounding/shift/clamp with headroom
//   sat_max      - largest unsigned value representable in out_w bits
package srcnn_pkg;

    typedef enum logic [1:0] {
        S_ACC  = 2'd0,
        S_BIAS = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    function automatic int clog2_int(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int acc_width(input int prod_w, input int taps);
        return prod_w + clog2_int(taps) + 1;
    endfunction

    function automatic int sum_width(input int acc_w, input int bias_w);
        return ((acc_w > bias_w) ? acc_w : bias_w) + 1;
    endfunction

    // Wide enough for the bias sum, the rounding constant and an
    // unambiguous signed compare against the output ceiling.
    function automatic int work_width(input int sum_w, input int shift, input int out_w);
        int w;
        w = sum_w;
        if (shift + 1 > w) w = shift + 1;
        if (out_w + 1 > w) w = out_w + 1;
        return w + 1;
    endfunction

    function automatic longint unsigned sat_max(input int out_w);
        return (64'd1 << out_w) - 64'd1;
    endfunction

endpackage

// File: rtl/srcnn_sat_shift.sv
// Combinational bias-add, optional round, arithmetic right shift and
// unsigned clamp. Negative results clamp to zero (implicit ReLU).
// Shared by all conv layers.
// Build option: SRCNN_MAC_ROUND_EN adds 2^(SHIFT-1) before the shift
// (round half up); undefined gives a plain floor shift.
// Ports:
//   acc   in  ACC_W   signed window sum
//   bias  in  BIAS_W  signed bias
//   data  out OUT_W   clamped result
//   sat   out 1       result was clamped high or low
module srcnn_sat_shift
    import srcnn_pkg::*;
#(
    parameter int ACC_W  = 22,
    parameter int BIAS_W = 16,
    parameter int SHIFT  = 8,
    parameter int OUT_W  = 8
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [BIAS_W-1:0] bias,
    output logic [OUT_W-1:0]         data,
    output logic                     sat
);

    localparam int SUM_W = sum_width(ACC_W, BIAS_W);
    localparam int W     = work_width(SUM_W, SHIFT, OUT_W);
    localparam int RSH   = (SHIFT > 0) ? SHIFT - 1 : 0;

`ifdef SRCNN_MAC_ROUND_EN
    localparam logic signed [W-1:0] RND = (SHIFT > 0) ? (W'(1) << RSH) : '0;
`else
    localparam logic signed [W-1:0] RND = '0;
`endif

    localparam logic signed [W-1:0] LIM = W'(sat_max(OUT_W));

    logic signed [W-1:0] acc_x;
    logic signed [W-1:0] bias_x;
    logic signed [W-1:0] sum;
    logic signed [W-1:0] r;

    assign acc_x  = {{(W-ACC_W){acc[ACC_W-1]}}, acc};
    assign bias_x = {{(W-BIAS_W){bias[BIAS_W-1]}}, bias};

    always_comb begin
        sum  = acc_x + bias_x + RND;
        r    = sum >>> SHIFT;
        data = r[OUT_W-1:0];
        sat  = 1'b0;
        if (r < 0) begin
            data = '0;
            sat  = 1'b1;
        end else if (r > LIM) begin
            data = '1;
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/srcnn_conv_mac_acc.sv
// Accumulates TAPS unsigned products per kernel window, adds the per-filter
// bias captured with the first tap, then rounds/shifts/clamps through
// srcnn_sat_shift and presents one result per window on a valid/ready port.
// Build option: SRCNN_MAC_ROUND_EN (round half up before the shift).
// Ports:
//   ap_clk, ap_rst_n          clock, async active-low reset
//   clr                       sync abort of partial window and pending result
//   in_valid/in_ready/in_prod product stream
//   bias                      signed bias, sampled on the first tap
//   out_valid/out_ready       result handshake
//   out_data/out_sat          clamped result and clamp flag
//
// state  | meaning
// S_ACC  | accepting products, accumulating the window
// S_BIAS | window complete, registering bias/shift/clamp result
// S_OUT  | result held until out_ready
module srcnn_conv_mac_acc
    import srcnn_pkg::*;
#(
    parameter int TAPS   = 9,
    parameter int PROD_W = 17,
    parameter int BIAS_W = 16,
    parameter int SHIFT  = 8,
    parameter int OUT_W  = 8
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic [BIAS_W-1:0] bias,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_sat
);

    localparam int ACC_W = acc_width(PROD_W, TAPS);
    // Counts up to TAPS itself so the increment on the last tap never wraps.
    localparam int CNT_W = (clog2_int(TAPS + 1) > 0) ? clog2_int(TAPS + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TAPS - 1);

    state_t state;
    state_t state_nx;

    logic [CNT_W-1:0]         cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [BIAS_W-1:0] bias_q;
    logic signed [ACC_W-1:0]  prod_x;
    logic [OUT_W-1:0]         sat_data;
    logic                     sat_flag;

    assign prod_x    = signed'({{(ACC_W-PROD_W){1'b0}}, in_prod});
    assign in_ready  = (state == S_ACC);
    assign out_valid = (state == S_OUT);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= S_ACC;
        else           state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (clr) begin
            state_nx = S_ACC;
        end else begin
            case (state)
                S_ACC:   if (in_valid && cnt == CNT_LAST) state_nx = S_BIAS;
                S_BIAS:  state_nx = S_OUT;
                S_OUT:   if (out_ready) state_nx = S_ACC;
                default: state_nx = S_ACC;
            endcase
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            bias_q   <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            case (state)
                S_ACC: begin
                    if (in_valid) begin
                        // First tap reloads instead of adding, so no explicit
                        // accumulator clear is needed between windows.
                        if (cnt == '0) begin
                            acc    <= prod_x;
                            bias_q <= signed'(bias);
                        end else begin
                            acc <= acc + prod_x;
                        end
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_BIAS: begin
                    out_data <= sat_data;
                    out_sat  <= sat_flag;
                end
                S_OUT: begin
                    if (out_ready) cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    srcnn_sat_shift #(
        .ACC_W  (ACC_W),
        .BIAS_W (BIAS_W),
        .SHIFT  (SHIFT),
        .OUT_W  (OUT_W)
    ) u_sat_shift (
        .acc  (acc),
        .bias (bias_q),
        .data (sat_data),
        .sat  (sat_flag)
    );

endmodule

// File: tb/tb_srcnn_conv_mac_acc.sv
module tb_srcnn_conv_mac_acc;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] in_prod;
    logic [15:0] bias;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_sat;

    int total;
    int bad;

`ifdef SRCNN_MAC_ROUND_EN
    localparam int E100    = 4;   // (900 + 128) >> 8
    localparam int ENEGSAT = 0;   // (900 - 1000 + 128) >> 8 = 0, no clamp
`else
    localparam int E100    = 3;   // 900 >> 8
    localparam int ENEGSAT = 1;   // -100 >>> 8 = -1, clamps to 0
`endif

    srcnn_conv_mac_acc #(
        .TAPS   (9),
        .PROD_W (17),
        .BIAS_W (16),
        .SHIFT  (8),
        .OUT_W  (8)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Nine taps back to back, then checks the N+1 / N+2 valid latency.
    task automatic feed(input int p, input int b);
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_prod  = 17'(p);
            bias     = 16'(b);
            tick();
        end
        in_valid = 1'b0;
        chk("lat_n1", 32'(out_valid), 32'd0);
        tick();
        chk("lat_n2", 32'(out_valid), 32'd1);
    endtask

    task automatic take(input string tag, input int exp_d, input int exp_s);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(exp_d));
        chk({tag, "_sat"}, 32'(out_sat), 32'(exp_s));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        ap_rst_n  = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        bias      = '0;
        out_ready = 1'b0;

        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        #11 ap_rst_n = 1'b1;
        tick();

        feed(100, 0);
        take("w100", E100, 0);

        feed(131071, 0);
        take("wmax", 255, 1);

        feed(100, -1000);
        take("wneg", 0, ENEGSAT);

        feed(1000, 300);        // 9300 >> 8 = 36
        take("wbias", 36, 0);

        feed(7253, 3);          // 65280 >> 8 = 255 exactly
        take("edge255", 255, 0);

        feed(7253, 259);        // 65536 >> 8 = 256
        take("edge256", 255, 1);

        // Stall: products offered while the result waits must be ignored.
        feed(100, 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_prod  = 17'd5000;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(E100));
            chk("stall_ready", 32'(in_ready), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        take("stall_res", E100, 0);
        feed(100, 0);
        take("after_stall", E100, 0);

        // clr while a result is pending discards it.
        feed(100, 0);
        clr       = 1'b1;
        out_ready = 1'b1;
        tick();
        clr       = 1'b0;
        out_ready = 1'b0;
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        chk("clr_in_ready", 32'(in_ready), 32'd1);

        // clr after 4 taps; only the following window produces a result.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_prod  = 17'd50;
            bias     = 16'd0;
            tick();
        end
        clr = 1'b1;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_mid_valid", 32'(out_valid), 32'd0);
        feed(10, 256);          // (90 + 256) >> 8 = 1
        take("clr_win", 1, 0);

        // Async reset mid-window.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_prod  = 17'd500;
            bias     = 16'd0;
            tick();
        end
        in_valid = 1'b0;
        #2 ap_rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_out_sat", 32'(out_sat), 32'd0);
        #3 ap_rst_n = 1'b1;
        tick();
        feed(200, 0);           // 1800 >> 8 = 7
        take("arst_win", 7, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
